// File: rtl/column_feeder.sv
// Column feeder: streams a 32 x 16-bit frame buffer to a column-scanned display,
// one LOAD strobe per column, preceded by an IN_CLR burst at frame start.
module column_feeder #(
    parameter int CLR_CYCLES = 2,
    parameter int LOAD_HIGH  = 4,
    parameter int LOAD_LOW   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        START,
    input  logic        CONT,
    output logic [15:0] out_column,
    output logic        LOAD,
    output logic        IN_CLR,
    output logic [4:0]  col_idx,
    output logic        BUSY,
    output logic        DONE,
    output logic [2:0]  state_dbg
);

    // Protocol: START is a level sampled only in IDLE (no ready; ignored while BUSY).
    // wr_en writes are always accepted on the same edge. CONT is sampled once, on the
    // edge that ends the last LOAD-low cycle of column 31.
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_LHI   = 3'd3;
    localparam logic [2:0] S_LLO   = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
    localparam logic [3:0] HI_LAST  = 4'(LOAD_HIGH - 1);
    localparam logic [3:0] LO_LAST  = 4'(LOAD_LOW - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  col_next;
    logic [15:0] out_q, out_d;
    logic        load_q, load_d;
    logic        in_clr_q, in_clr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] mem_q [32];
    logic [15:0] mem_d [32];

    assign col_next = col_q + 5'd1;

    // The counter holds "cycles remaining minus one" and is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLR_LAST;
                    col_d   = 5'd0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SETUP;
                    cnt_d   = 4'd0;
                    out_d   = mem_q[col_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SETUP: begin
                state_d = S_LHI;
                cnt_d   = HI_LAST;
            end
            S_LHI: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_LLO;
                    cnt_d   = LO_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_LLO: begin
                if (cnt_q == 4'd0) begin
                    cnt_d = 4'd0;
                    if (col_q != 5'd31) begin
                        state_d = S_SETUP;
                        col_d   = col_next;
                        out_d   = mem_q[col_next];
                    end else begin
                        col_d = 5'd0;
                        if (CONT) begin
                            state_d = S_SETUP;
                            out_d   = mem_q[5'd0];
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                col_d   = 5'd0;
            end
        endcase
    end

    // Strobes are decoded from the next state so they are flops aligned with the state.
    always_comb begin
        load_d   = (state_d == S_LHI);
        in_clr_d = (state_d == S_CLEAR);
        done_d   = (state_d == S_FIN);
        busy_d   = (state_d != S_IDLE);
    end

    // Reads above use mem_q, so a same-edge write to the SETUP entry presents old data.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            col_q    <= 5'd0;
            out_q    <= 16'h0000;
            load_q   <= 1'b0;
            in_clr_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            out_q    <= out_d;
            load_q   <= load_d;
            in_clr_q <= in_clr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign out_column = out_q;
    assign LOAD       = load_q;
    assign IN_CLR     = in_clr_q;
    assign col_idx    = col_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_column_feeder.sv
// Bench for column_feeder: a frame-timeline model predicts every output each cycle,
// directed scenarios pin latencies and data literally, then randomized traffic runs.
module tb_column_feeder;

    localparam int CLR  = 2;
    localparam int LH   = 4;
    localparam int LL   = 4;
    localparam int P    = 1 + LH + LL;
    localparam int FEND = CLR + 32 * P;

    logic        CLK;
    logic        RESET;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start, cont, start_f;
    logic [15:0] out_column, out_column_f;
    logic        LOAD, IN_CLR, BUSY, DONE;
    logic        LOAD_f, IN_CLR_f, BUSY_f, DONE_f;
    logic [4:0]  col_idx, col_idx_f;
    logic [2:0]  state_dbg, state_dbg_f;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    column_feeder dut (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .START(start), .CONT(cont), .out_column(out_column), .LOAD(LOAD), .IN_CLR(IN_CLR),
        .col_idx(col_idx), .BUSY(BUSY), .DONE(DONE), .state_dbg(state_dbg)
    );

    column_feeder #(.CLR_CYCLES(1), .LOAD_HIGH(1), .LOAD_LOW(1)) dut_fast (
        .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .START(start_f), .CONT(1'b0), .out_column(out_column_f), .LOAD(LOAD_f), .IN_CLR(IN_CLR_f),
        .col_idx(col_idx_f), .BUSY(BUSY_f), .DONE(DONE_f), .state_dbg(state_dbg_f)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // frame-timeline model: m_pos is the cycle position inside a transfer
    bit          m_busy;
    int          m_pos;
    logic [15:0] m_mem [32];
    logic [15:0] e_out;
    logic        e_load, e_clr, e_busy, e_done;
    logic [4:0]  e_col;

    always @(posedge CLK or posedge RESET) begin : model
        int c, ph;
        if (RESET) begin
            m_busy = 0; m_pos = 0;
            for (int i = 0; i < 32; i++) m_mem[i] = 16'h0;
            e_out = 16'h0; e_load = 0; e_clr = 0; e_busy = 0; e_done = 0; e_col = 5'd0;
        end else begin
            if (!m_busy) begin
                if (start) begin m_busy = 1; m_pos = 0; end
            end else begin
                m_pos++;
                if (m_pos == FEND && cont) m_pos = CLR;
                else if (m_pos > FEND) m_busy = 0;
            end
            e_busy = m_busy;
            e_clr  = m_busy && (m_pos < CLR);
            e_done = m_busy && (m_pos == FEND);
            e_load = 0;
            e_col  = 5'd0;
            if (m_busy && m_pos >= CLR && m_pos < FEND) begin
                c  = (m_pos - CLR) / P;
                ph = (m_pos - CLR) % P;
                e_col  = 5'(c);
                e_load = (ph >= 1) && (ph <= LH);
                if (ph == 0) e_out = m_mem[c];
            end
            if (wr_en) m_mem[wr_addr] = wr_data;
        end
    end

    // scoreboard
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("out_column", out_column, e_out);
            check("LOAD", 16'(LOAD), 16'(e_load));
            check("IN_CLR", 16'(IN_CLR), 16'(e_clr));
            check("col_idx", 16'(col_idx), 16'(e_col));
            check("BUSY", 16'(BUSY), 16'(e_busy));
            check("DONE", 16'(DONE), 16'(e_done));
        end
    end

    // driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic write_buf(input logic [4:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge CLK);
        wr_en = 0;
    endtask

    task automatic do_reset();
        #2 RESET = 1;
        #1;
        check("rst_out_column", out_column, 16'h0000);
        check("rst_LOAD", 16'(LOAD), 16'h0);
        check("rst_IN_CLR", 16'(IN_CLR), 16'h0);
        check("rst_BUSY", 16'(BUSY), 16'h0);
        check("rst_DONE", 16'(DONE), 16'h0);
        check("rst_col_idx", 16'(col_idx), 16'h0);
        @(negedge CLK);
        #2 RESET = 0;
        @(negedge CLK);
    endtask

    task automatic wait_col_load(input logic [4:0] c, output bit ok);
        ok = 0;
        for (int i = 0; i < 700; i++) begin
            if (col_idx == c && LOAD) begin ok = 1; break; end
            @(negedge CLK);
        end
        check("wait_col_load_timeout", 16'(ok), 16'h1);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 700; i++) begin
            if (DONE) begin seen = 1; break; end
            @(negedge CLK);
        end
        check("wait_done_timeout", 16'(seen), 16'h1);
    endtask

    task automatic measure_frame(input bit fast, output int done_cyc, output int clr_cnt,
                                 output int falls, output int hi_cnt);
        bit prev;
        logic ld, clr, dn;
        done_cyc = 0; clr_cnt = 0; falls = 0; hi_cnt = 0; prev = 0;
        if (fast) start_f = 1; else start = 1;
        @(posedge CLK);
        @(negedge CLK);
        start = 0; start_f = 0;
        for (int n = 0; n < 1000; n++) begin
            ld  = fast ? LOAD_f : LOAD;
            clr = fast ? IN_CLR_f : IN_CLR;
            dn  = fast ? DONE_f : DONE;
            if (clr) clr_cnt++;
            if (ld) hi_cnt++;
            if (prev && !ld) falls++;
            prev = ld;
            if (dn) begin done_cyc = n + 1; break; end
            @(negedge CLK);
        end
    endtask

    initial begin : stimulus
        int dc, cc, fc, hc, dn_cnt;
        bit ok;
        RESET = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
        start = 0; cont = 0; start_f = 0;
        @(negedge CLK);
        #2 RESET = 0;
        chk_en = 1;
        @(negedge CLK);
        check("reset_busy", 16'(BUSY), 16'h0);
        check("reset_state", 16'(state_dbg), 16'h0);

        // walking-one pattern, single frame
        for (int k = 0; k < 32; k++) write_buf(5'(k), 16'h0001 << (k % 16));
        idle(2);
        measure_frame(0, dc, cc, fc, hc);
        check("frame_done_cycle", 16'(dc), 16'd291);
        check("frame_in_clr_cycles", 16'(cc), 16'd2);
        check("frame_load_falls", 16'(fc), 16'd32);
        check("frame_load_high_cycles", 16'(hc), 16'd128);
        idle(3);

        // write the presented column mid-pulse; effect only next frame
        start = 1; @(negedge CLK); start = 0;
        wait_col_load(5'd5, ok);
        write_buf(5'd5, 16'hFFFF);
        check("col5_keeps_old", out_column, 16'h0020);
        idle(2);
        check("col5_still_old", out_column, 16'h0020);
        wait_done();
        idle(3);
        start = 1; @(negedge CLK); start = 0;
        wait_col_load(5'd5, ok);
        check("col5_new_frame", out_column, 16'hFFFF);
        wait_done();
        idle(3);

        // continuous mode: no clear, no done at wrap
        cont = 1;
        start = 1; @(negedge CLK); start = 0;
        cc = 0; dn_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            if (IN_CLR) cc++;
            if (DONE) dn_cnt++;
            @(negedge CLK);
        end
        check("cont_in_clr_cycles", 16'(cc), 16'd2);
        check("cont_no_done", 16'(dn_cnt), 16'd0);
        cont = 0;
        wait_done();
        idle(3);

        // START held: one frame per IDLE entry
        start = 1;
        dn_cnt = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            if (DONE) dn_cnt++;
        end
        start = 0;
        check("start_held_done_count", 16'(dn_cnt), 16'd2);
        wait_done();
        idle(3);

        // reset mid-frame at column 12 in LOAD high
        start = 1; @(negedge CLK); start = 0;
        wait_col_load(5'd12, ok);
        do_reset();
        idle(20);
        start = 1; @(negedge CLK); start = 0;
        wait_col_load(5'd0, ok);
        check("post_reset_buf_zero", out_column, 16'h0000);
        wait_done();
        idle(3);

        // minimum-timing instance
        measure_frame(1, dc, cc, fc, hc);
        check("fast_done_cycle", 16'(dc), 16'd98);
        check("fast_in_clr_cycles", 16'(cc), 16'd1);
        check("fast_load_falls", 16'(fc), 16'd32);
        check("fast_load_high_cycles", 16'(hc), 16'd32);
        idle(3);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 5'($urandom_range(0, 31));
            wr_data = 16'($urandom);
            start   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) cont = ~cont;
            if ($urandom_range(0, 1499) == 0) begin
                wr_en = 0; start = 0;
                do_reset();
            end else begin
                @(negedge CLK);
            end
        end
        wr_en = 0; start = 0; cont = 0;
        idle(700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/column_feeder.md
COLUMN_FEEDER -- requirements
Module: column_feeder

Interface
REQ-001 SHALL have parameter CLR_CYCLES, default 2, number of cycles IN_CLR is held high at frame start (range 1..15).
REQ-002 SHALL have parameter LOAD_HIGH, default 4, number of cycles LOAD is held high per column (range 1..15).
REQ-003 SHALL have parameter LOAD_LOW, default 4, number of cycles LOAD is held low after each falling edge (range 1..15).
REQ-004 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en  input  1  frame-buffer write strobe.
REQ-007 SHALL have port wr_addr  input  5  frame-buffer column address 0..31.
REQ-008 SHALL have port wr_data  input  16  column pixel data.
REQ-009 SHALL have port START  input  1  level; starts one frame transfer when sampled high in IDLE.
REQ-010 SHALL have port CONT  input  1  continuous mode; sampled at end of last column.
REQ-011 SHALL have port out_column  output  16  column data to the display's in_column.
REQ-012 SHALL have port LOAD  output  1  column strobe; display advances its column on falling edge.
REQ-013 SHALL have port IN_CLR  output  1  display input-clear strobe.
REQ-014 SHALL have port col_idx  output  5  index of column currently presented.
REQ-015 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-017 SHALL hold a 32 x 16-bit frame buffer; wr_en=1 writes wr_data to entry wr_addr on the same edge, in any state.
REQ-018 SHALL implement FSM states IDLE, CLEAR, SETUP, LHI, LLO, FIN.
REQ-019 IDLE: START=1 -> CLEAR next cycle, col_idx=0; START ignored in all other states.
REQ-020 CLEAR: IN_CLR=1 for exactly CLR_CYCLES cycles, then SETUP.
REQ-021 SETUP: one cycle; out_column registered from buffer[col_idx] on entry edge; LOAD=0.
REQ-022 LHI: LOAD=1 for exactly LOAD_HIGH cycles; out_column stable.
REQ-023 LLO: LOAD=0 for exactly LOAD_LOW cycles; out_column stable through final LLO cycle.
REQ-024 LLO end, col_idx<31: col_idx+1 -> SETUP.
REQ-025 LLO end, col_idx=31: col_idx wraps to 0; CONT=1 -> SETUP (no CLEAR, no DONE); CONT=0 -> FIN.
REQ-026 FIN: DONE=1 for one cycle, BUSY=1, then IDLE; DONE SHALL NOT assert in continuous mode.
REQ-027 Frame latency with defaults: START sampled at edge 0 -> DONE high in cycle 2+32*9+1=291 after edge 0; exactly 32 LOAD falling edges per frame.
REQ-028 Write to buffer[col_idx] during SETUP/LHI/LLO SHALL NOT change out_column for the current column; takes effect next frame.
REQ-029 Same-cycle write and SETUP read of one entry SHALL present the old data.
REQ-030 LOAD and IN_CLR SHALL be registered outputs, glitch-free, never high simultaneously.
REQ-031 Internal cycle counter SHALL be 4 bits and reload on every state entry.

Reset
REQ-032 RESET=1 SHALL immediately force IDLE, out_column=16'h0000, LOAD=0, IN_CLR=0, col_idx=0, BUSY=0, DONE=0, all buffer entries 16'h0000, independent of CLK.
REQ-033 Reset mid-frame SHALL abort the transfer; after release, no LOAD/IN_CLR activity until a new START.

Verification
REQ-034 Reset, write buffer[k]=16'h0001<<(k%16) for k=0..31, START pulse, CONT=0 -> IN_CLR high 2 cycles, 32 LOAD pulses each 4 high/4 low, out_column matches buffer[k] across each pulse, DONE at cycle 291.
REQ-035 CONT=1 held -> after column 31, col_idx=0 and SETUP follows with no IN_CLR, no DONE; drop CONT -> DONE after next column 31.
REQ-036 Write buffer[5]=16'hFFFF while col_idx=5 in LHI (old 16'h0020) -> out_column stays 16'h0020; next frame shows 16'hFFFF.
REQ-037 START held high through frame and during BUSY -> exactly one frame per IDLE entry; START during BUSY has no effect.
REQ-038 RESET asserted in LHI at col_idx=12 -> LOAD, BUSY low asynchronously, out_column=0, buffer reads 0 on next frame.
REQ-039 Parameters CLR_CYCLES=1, LOAD_HIGH=1, LOAD_LOW=1 -> frame DONE at cycle 1+32*3+1=98; no LOAD pulse narrower than one cycle.
